cpu_mc: RTL

//  Parametrised multicycle 3-address accumulator-less CPU, successor of the first-generation cpu.

---
 rtl/cpu_mc.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_mc.sv
// Multicycle three-address CPU that fetches 1- or 2-word instructions from a synchronous single-port RAM.
// Define CPU_DIV_EN to build the unsigned divider for opcode 0100; without it that opcode is a NOP.
module cpu_mc #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int PC_START   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] mem_in,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  halted
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [3:0] {
    S_FETCH_HI, S_WAIT_HI, S_DECODE, S_FETCH_LO, S_WAIT_LO, S_RD_IND,
    S_RD_OP, S_EXEC, S_IN_WAIT, S_WR_IND, S_WRITE, S_HALT
  } state_t;

  localparam logic [3:0] OC_MOV  = 4'h0;
  localparam logic [3:0] OC_ADD  = 4'h1;
  localparam logic [3:0] OC_SUB  = 4'h2;
  localparam logic [3:0] OC_MUL  = 4'h3;
`ifdef CPU_DIV_EN
  localparam logic [3:0] OC_DIV  = 4'h4;
`endif
  localparam logic [3:0] OC_IN   = 4'h5;
  localparam logic [3:0] OC_OUT  = 4'h6;
  localparam logic [3:0] OC_STOP = 4'hF;

  state_t             state_q, state_d;
  logic               ph_q, ph_d;
  logic               fetch_armed_q;
  logic [15:0]        ir_q, ir_d;
  logic [2:0]         pend_q, pend_d;
  logic [1:0]         opi_q, opi_d;
  logic [2:0][DW-1:0] val_q, val_d;
  logic [DW-1:0]      res_q, res_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW-1:0]      sp_q;
  logic               mem_we_q, mem_we_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_data_q, mem_data_d;
  logic [DW-1:0]      out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               halted_q, halted_d;

  logic [3:0]         oc;
  logic [2:0][3:0]    fld;
  logic               go_fetch, go_next, go_dest;
  logic [2:0]         pend_n;
  logic [DW-1:0]      dest_val;
  logic [1:0]         nxt;

  // fld[0] is op1 (destination), fld[2] is op3; each is {indirect, addr[2:0]}.
  assign oc  = ir_q[15:12];
  assign fld = {ir_q[3:0], ir_q[7:4], ir_q[11:8]};

  function automatic logic [AW-1:0] fld_addr(input logic [3:0] f);
    return AW'(f[2:0]);
  endfunction

  // mem_addr is registered, so every state that starts a read loads the address on its way in;
  // the target state then spends one cycle with the address on the bus and one with data on mem_in.
  always_comb begin
    // NOTE: every variable gets a default here so no path through the case can infer a latch.
    state_d     = state_q;
    ph_d        = ph_q;
    ir_d        = ir_q;
    pend_d      = pend_q;
    opi_d       = opi_q;
    val_d       = val_q;
    res_d       = res_q;
    pc_d        = pc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    in_ready_d  = 1'b0;
    halted_d    = halted_q;
    go_fetch    = 1'b0;
    go_next     = 1'b0;
    go_dest     = 1'b0;
    pend_n      = pend_q;
    dest_val    = res_q;
    nxt         = 2'd0;

    unique case (state_q)
      S_FETCH_HI: begin
        if (!fetch_armed_q) mem_addr_d = pc_q;
        else                state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        ir_d    = mem_in[15:0];
        pc_d    = pc_q + 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (oc)
          OC_MOV: begin
            if (fld[2] == 4'b1000) begin
              state_d    = S_FETCH_LO;
              mem_addr_d = pc_q;
            end else begin
              pend_n  = 3'b010;
              go_next = 1'b1;
            end
          end
`ifdef CPU_DIV_EN
          OC_ADD, OC_SUB, OC_MUL, OC_DIV: begin
`else
          OC_ADD, OC_SUB, OC_MUL: begin
`endif
            pend_n  = 3'b110;
            go_next = 1'b1;
          end
          OC_IN: begin
            state_d    = S_IN_WAIT;
            in_ready_d = 1'b1;
          end
          OC_OUT: begin
            pend_n  = 3'b001;
            go_next = 1'b1;
          end
          OC_STOP: begin
            if      (fld[0] != 4'd0) pend_n = 3'b001;
            else if (fld[1] != 4'd0) pend_n = 3'b010;
            else if (fld[2] != 4'd0) pend_n = 3'b100;
            else                     pend_n = 3'b000;
            if (pend_n == 3'b000) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              go_next = 1'b1;
            end
          end
          default: go_fetch = 1'b1;
        endcase
      end
      S_FETCH_LO: state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        pc_d     = pc_q + 1'b1;
        dest_val = mem_in;
        go_dest  = 1'b1;
      end
      S_RD_IND: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d       = 1'b0;
          state_d    = S_RD_OP;
          mem_addr_d = mem_in[AW-1:0];
        end
      end
      S_RD_OP: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          val_d[opi_q] = mem_in;
          pend_n       = pend_q & ~(3'b001 << opi_q);
          go_next      = 1'b1;
        end
      end
      S_EXEC: begin
        case (oc)
          OC_MOV: begin dest_val = val_q[1];            go_dest = 1'b1; end
          OC_ADD: begin dest_val = val_q[1] + val_q[2]; go_dest = 1'b1; end
          OC_SUB: begin dest_val = val_q[1] - val_q[2]; go_dest = 1'b1; end
          OC_MUL: begin dest_val = val_q[1] * val_q[2]; go_dest = 1'b1; end
`ifdef CPU_DIV_EN
          OC_DIV: begin
            dest_val = (val_q[2] == '0) ? '1 : val_q[1] / val_q[2];
            go_dest  = 1'b1;
          end
`endif
          OC_OUT: begin
            out_d       = val_q[0];
            out_valid_d = 1'b1;
            go_fetch    = 1'b1;
          end
          OC_STOP: begin
            out_d       = val_q[opi_q];
            out_valid_d = 1'b1;
            halted_d    = 1'b1;
            state_d     = S_HALT;
          end
          default: go_fetch = 1'b1;
        endcase
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          dest_val = in;
          go_dest  = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_WR_IND: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d       = 1'b0;
          state_d    = S_WRITE;
          mem_we_d   = 1'b1;
          mem_addr_d = mem_in[AW-1:0];
          mem_data_d = res_q;
        end
      end
      S_WRITE: go_fetch = 1'b1;
      S_HALT:  state_d  = S_HALT;
      default: go_fetch = 1'b1;
    endcase

    // Start the lowest pending operand read, or execute once all operands are in.
    if (go_next) begin
      pend_d = pend_n;
      if (pend_n == 3'b000) begin
        state_d = S_EXEC;
      end else begin
        nxt        = pend_n[0] ? 2'd0 : (pend_n[1] ? 2'd1 : 2'd2);
        opi_d      = nxt;
        ph_d       = 1'b0;
        mem_addr_d = fld_addr(fld[nxt]);
        state_d    = fld[nxt][3] ? S_RD_IND : S_RD_OP;
      end
    end

    if (go_dest) begin
      res_d      = dest_val;
      ph_d       = 1'b0;
      mem_addr_d = fld_addr(fld[0]);
      if (fld[0][3]) begin
        state_d = S_WR_IND;
      end else begin
        state_d    = S_WRITE;
        mem_we_d   = 1'b1;
        mem_data_d = dest_val;
      end
    end

    if (go_fetch) begin
      state_d    = S_FETCH_HI;
      mem_addr_d = pc_q;
    end
  end

  // fetch_armed_q covers the first cycle after reset, when mem_addr is 0 rather than pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH_HI;
      ph_q          <= 1'b0;
      fetch_armed_q <= 1'b0;
      ir_q          <= '0;
      pend_q        <= '0;
      opi_q         <= '0;
      val_q         <= '0;
      res_q         <= '0;
      pc_q          <= AW'(PC_START);
      sp_q          <= '1;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignment so all of them update from the same pre-edge values.
      state_q       <= state_d;
      ph_q          <= ph_d;
      fetch_armed_q <= 1'b1;
      ir_q          <= ir_d;
      pend_q        <= pend_d;
      opi_q         <= opi_d;
      val_q         <= val_d;
      res_q         <= res_d;
      pc_q          <= pc_d;
      sp_q          <= sp_q;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      halted_q      <= halted_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign sp        = sp_q;
  assign halted    = halted_q;

endmodule
